pong_raster_scanner: RTL and testbench

Upstream stage of the paddle/ball logic. Generates the xCount/yCount raster coordinates that PaddleControl and the other game-object blocks consume to decide drawPaddle and friends. Paces the scan one pixel at a time against the LCD writer's ready handshake. Inserts an inter-frame gap in which game objects update their positions, and signals frame boundaries.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_gap_timer.sv | 33 +++
 rtl/pong_raster_scanner.sv | 147 ++++++++++++++
 tb/tb_pong_raster_scanner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game-object pipeline.
package pong_pkg;

  // Physical LCD geometry and the coordinate widths every game-object block uses.
  localparam int unsigned SCREEN_W = 32'd240;
  localparam int unsigned SCREEN_H = 32'd320;
  localparam int unsigned X_BITS   = 32'd8;
  localparam int unsigned Y_BITS   = 32'd9;

  // Raster scanner control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } scanState_t;

  // Bits needed by a down-counter that must hold values up to maxCount (never below 1).
  function automatic int unsigned timerBits(input int unsigned maxCount);
    int unsigned bits;
    bits = $clog2(maxCount + 32'd1);
    if (bits < 32'd1) begin
      bits = 32'd1;
    end else begin
      bits = bits;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pong_gap_timer.sv
// Loadable down-counter. done is a registered one-cycle pulse that is high in
// the cycle the count sits at zero after a load, so a load of N-1 yields done
// N cycles after the load edge. A load of zero pulses done immediately.
module pong_gap_timer #(
  parameter int unsigned CW = 32'd5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] loadValue,
  output logic          done
);

  logic [CW-1:0] count_r;

  // Count down from the loaded value and flag the arrival at zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
      done    <= 1'b0;
    end else if (load) begin
      count_r <= loadValue;
      done    <= (loadValue == {CW{1'b0}});
    end else if (count_r != {CW{1'b0}}) begin
      count_r <= count_r - CW'(1);
      done    <= (count_r == CW'(1));
    end else begin
      count_r <= count_r;
      done    <= 1'b0;
    end
  end

endmodule

// File: rtl/pong_raster_scanner.sv
// Raster coordinate generator for the pong game objects. Walks x/y across the
// screen one pixel per accepted handshake with the LCD writer, inserts an idle
// gap between frames for object updates, and flags frame boundaries.
// X_BITS/Y_BITS must be wide enough to hold WIDTH-1/HEIGHT-1.
module pong_raster_scanner #(
  parameter int unsigned WIDTH      = pong_pkg::SCREEN_W,
  parameter int unsigned HEIGHT     = pong_pkg::SCREEN_H,
  parameter int unsigned X_BITS     = pong_pkg::X_BITS,
  parameter int unsigned Y_BITS     = pong_pkg::Y_BITS,
  parameter int unsigned GAP_CYCLES = 32'd16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              pixelReady,
  output logic [X_BITS-1:0] xCount,
  output logic [Y_BITS-1:0] yCount,
  output logic              pixelWrite,
  output logic              frameStart,
  output logic              frameDone,
  output logic [15:0]       frameCount
);

  import pong_pkg::*;

  localparam int unsigned GAP_BITS = timerBits(GAP_CYCLES);
  localparam logic [X_BITS-1:0]   X_LAST   = X_BITS'(WIDTH - 32'd1);
  localparam logic [Y_BITS-1:0]   Y_LAST   = Y_BITS'(HEIGHT - 32'd1);
  // The timer pulses done on the last gap cycle, hence the minus one.
  localparam logic [GAP_BITS-1:0] GAP_LOAD = GAP_BITS'(GAP_CYCLES - 32'd1);

  scanState_t        state_r;
  scanState_t        nextState_s;
  logic [X_BITS-1:0] nextX_s;
  logic [Y_BITS-1:0] nextY_s;
  logic              nextWrite_s;
  logic              nextStart_s;
  logic              nextDone_s;
  logic [15:0]       nextCount_s;
  logic              gapLoad_s;
  logic              gapDone_s;
  logic              accept_s;

  assign accept_s = pixelWrite & pixelReady;

  pong_gap_timer #(
    .CW(GAP_BITS)
  ) gapTimer (
    .clock     (clock),
    .reset     (reset),
    .load      (gapLoad_s),
    .loadValue (GAP_LOAD),
    .done      (gapDone_s)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    nextState_s = state_r;
    nextX_s     = xCount;
    nextY_s     = yCount;
    nextWrite_s = 1'b0;
    nextStart_s = 1'b0;
    nextDone_s  = 1'b0;
    nextCount_s = frameCount;
    gapLoad_s   = 1'b0;
    case (state_r)
      IDLE: begin
        nextX_s = {X_BITS{1'b0}};
        nextY_s = {Y_BITS{1'b0}};
        if (enable) begin
          nextState_s = SCAN;
          nextWrite_s = 1'b1;
          nextStart_s = 1'b1;
        end else begin
          nextState_s = IDLE;
        end
      end
      SCAN: begin
        // Coordinates hold while the writer stalls; frameStart never re-fires.
        nextWrite_s = 1'b1;
        if (accept_s) begin
          if (xCount < X_LAST) begin
            nextX_s = xCount + X_BITS'(1);
          end else begin
            nextX_s = {X_BITS{1'b0}};
            if (yCount < Y_LAST) begin
              nextY_s = yCount + Y_BITS'(1);
            end else begin
              // Last pixel of the frame accepted.
              nextY_s     = {Y_BITS{1'b0}};
              nextWrite_s = 1'b0;
              nextDone_s  = 1'b1;
              nextCount_s = frameCount + 16'd1;
              gapLoad_s   = 1'b1;
              nextState_s = GAP;
            end
          end
        end else begin
          nextX_s = xCount;
          nextY_s = yCount;
        end
      end
      GAP: begin
        nextX_s = {X_BITS{1'b0}};
        nextY_s = {Y_BITS{1'b0}};
        if (gapDone_s) begin
          if (enable) begin
            nextState_s = SCAN;
            nextWrite_s = 1'b1;
            nextStart_s = 1'b1;
          end else begin
            nextState_s = IDLE;
          end
        end else begin
          nextState_s = GAP;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextX_s     = {X_BITS{1'b0}};
        nextY_s     = {Y_BITS{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress silently.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r    <= IDLE;
      xCount     <= {X_BITS{1'b0}};
      yCount     <= {Y_BITS{1'b0}};
      pixelWrite <= 1'b0;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
      frameCount <= 16'd0;
    end else begin
      state_r    <= nextState_s;
      xCount     <= nextX_s;
      yCount     <= nextY_s;
      pixelWrite <= nextWrite_s;
      frameStart <= nextStart_s;
      frameDone  <= nextDone_s;
      frameCount <= nextCount_s;
    end
  end

endmodule

// File: tb/tb_pong_raster_scanner.sv
// Directed bench for pong_raster_scanner on a 4x3 screen with a 2-cycle gap.
// Outputs are sampled 1 time unit after each rising edge, where inputs are
// also updated. obs packs {pixelWrite, frameStart, frameDone, xCount, yCount}.
module tb_pong_raster_scanner;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        pixelReady;
  logic [7:0]  xCount;
  logic [8:0]  yCount;
  logic        pixelWrite;
  logic        frameStart;
  logic        frameDone;
  logic [15:0] frameCount;

  int total;
  int bad;
  logic [19:0] exp;
  wire  [19:0] obs = {pixelWrite, frameStart, frameDone, xCount, yCount};

  pong_raster_scanner #(
    .WIDTH      (32'd4),
    .HEIGHT     (32'd3),
    .X_BITS     (32'd8),
    .Y_BITS     (32'd9),
    .GAP_CYCLES (32'd2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pixelReady (pixelReady),
    .xCount     (xCount),
    .yCount     (yCount),
    .pixelWrite (pixelWrite),
    .frameStart (frameStart),
    .frameDone  (frameDone),
    .frameCount (frameCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; pixelReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({obs, frameCount} !== 36'd0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: got obs=%h cnt=%h want all zero", i, obs, frameCount);
      end
    end
    reset = 1'b1;
    tick;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL first_start: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_full_scan;
    for (int i = 0; i < 12; i++) begin
      exp = {1'b1, (i == 0), 1'b0, 8'(i % 4), 9'(i / 4)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL scan_pixel %0d: got %h want %h", i, obs, exp);
      end
      tick;
    end
    exp = {1'b0, 1'b0, 1'b1, 8'd0, 9'd0};
    total++;
    if (obs !== exp || frameCount !== 16'd1) begin
      bad++;
      $display("FAIL scan_done: got %h cnt=%0d want %h cnt=1", obs, frameCount, exp);
    end
    tick;
    total++;
    if (obs !== 20'd0) begin
      bad++;
      $display("FAIL scan_gap2: got %h want 0", obs);
    end
    tick;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    total++;
    if (obs !== exp || frameCount !== 16'd1) begin
      bad++;
      $display("FAIL scan_restart: got %h cnt=%0d want %h cnt=1", obs, frameCount, exp);
    end
  endtask

  task automatic test_backpressure;
    repeat (6) tick;
    exp = {1'b1, 1'b0, 1'b0, 8'd2, 9'd1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL bp_reach: got %h want %h", obs, exp);
    end
    pixelReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL bp_hold %0d: got %h want %h", i, obs, exp);
      end
    end
    pixelReady = 1'b1;
    tick;
    exp = {1'b1, 1'b0, 1'b0, 8'd3, 9'd1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL bp_next: got %h want %h", obs, exp);
    end
    repeat (4) tick;
    exp = {1'b1, 1'b0, 1'b0, 8'd3, 9'd2};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL bp_last: got %h want %h", obs, exp);
    end
    tick;
    total++;
    if (frameDone !== 1'b1 || frameCount !== 16'd2) begin
      bad++;
      $display("FAIL bp_done: got done=%b cnt=%0d want done=1 cnt=2", frameDone, frameCount);
    end
    repeat (2) tick;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL bp_restart: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_enable_drop;
    repeat (5) tick;
    exp = {1'b1, 1'b0, 1'b0, 8'd1, 9'd1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL en_reach: got %h want %h", obs, exp);
    end
    enable = 1'b0;
    repeat (7) tick;
    exp = {1'b0, 1'b0, 1'b1, 8'd0, 9'd0};
    total++;
    if (obs !== exp || frameCount !== 16'd3) begin
      bad++;
      $display("FAIL en_done: got %h cnt=%0d want %h cnt=3", obs, frameCount, exp);
    end
    tick;
    tick;
    total++;
    if (obs !== 20'd0) begin
      bad++;
      $display("FAIL en_idle: got %h want 0", obs);
    end
    tick;
    total++;
    if (obs !== 20'd0) begin
      bad++;
      $display("FAIL en_idle_stay: got %h want 0", obs);
    end
    enable = 1'b1;
    tick;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    total++;
    if (obs !== exp || frameCount !== 16'd3) begin
      bad++;
      $display("FAIL en_restart: got %h cnt=%0d want %h cnt=3", obs, frameCount, exp);
    end
  endtask

  task automatic test_reset_mid;
    repeat (10) tick;
    exp = {1'b1, 1'b0, 1'b0, 8'd2, 9'd2};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL rm_reach: got %h want %h", obs, exp);
    end
    reset = 1'b0;
    tick;
    // Reset clears everything, frameCount included; no frameDone for the aborted frame.
    total++;
    if ({obs, frameCount} !== 36'd0) begin
      bad++;
      $display("FAIL rm_abort: got obs=%h cnt=%0d want all zero", obs, frameCount);
    end
    reset = 1'b1;
    tick;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    total++;
    if (obs !== exp || frameCount !== 16'd0) begin
      bad++;
      $display("FAIL rm_restart: got %h cnt=%0d want %h cnt=0", obs, frameCount, exp);
    end
  endtask

  task automatic test_wrap;
    force dut.frameCount = 16'hFFFF;
    #1;
    release dut.frameCount;
    total++;
    if (frameCount !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffff", frameCount);
    end
    repeat (12) tick;
    total++;
    if (frameDone !== 1'b1 || frameCount !== 16'd0) begin
      bad++;
      $display("FAIL wrap_done: got done=%b cnt=%h want done=1 cnt=0000", frameDone, frameCount);
    end
    tick;
    total++;
    if (frameDone !== 1'b0 || frameCount !== 16'd0) begin
      bad++;
      $display("FAIL wrap_pulse: got done=%b cnt=%h want done=0 cnt=0000", frameDone, frameCount);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    enable = 1'b0;
    pixelReady = 1'b0;
    test_reset;
    test_full_scan;
    test_backpressure;
    test_enable_drop;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
